// File: rtl/wb_arbiter_2x1.sv
// Two-master to one-slave Wishbone arbiter.
// Round-robin grant held for a whole CYC tenure; a watchdog aborts hung strobes with ERR.
module wb_arbiter_2x1 #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic [WB_ADDR_WIDTH-1:0]   m0_adr,
    input  logic [WB_DATA_WIDTH-1:0]   m0_dat_w,
    output logic [WB_DATA_WIDTH-1:0]   m0_dat_r,
    input  logic                       m0_cyc,
    input  logic                       m0_stb,
    input  logic                       m0_we,
    input  logic [WB_DATA_WIDTH/8-1:0] m0_sel,
    output logic                       m0_ack,
    output logic                       m0_err,

    input  logic [WB_ADDR_WIDTH-1:0]   m1_adr,
    input  logic [WB_DATA_WIDTH-1:0]   m1_dat_w,
    output logic [WB_DATA_WIDTH-1:0]   m1_dat_r,
    input  logic                       m1_cyc,
    input  logic                       m1_stb,
    input  logic                       m1_we,
    input  logic [WB_DATA_WIDTH/8-1:0] m1_sel,
    output logic                       m1_ack,
    output logic                       m1_err,

    output logic [WB_ADDR_WIDTH-1:0]   s_adr,
    output logic [WB_DATA_WIDTH-1:0]   s_dat_w,
    input  logic [WB_DATA_WIDTH-1:0]   s_dat_r,
    output logic                       s_cyc,
    output logic                       s_stb,
    output logic                       s_we,
    output logic [WB_DATA_WIDTH/8-1:0] s_sel,
    input  logic                       s_ack,
    input  logic                       s_err,

    output logic [1:0]                 grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_owner;
    logic   own_stb;
    logic   timeout_abort;

    assign own_stb = (state == GNT0) ? m0_stb :
                     (state == GNT1) ? m1_stb : 1'b0;

    // last_owner remembers who released most recently so a tie favours the other master
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
        end else begin
            state <= state_next;
            if (state == GNT0 && !m0_cyc) begin
                last_owner <= 1'b0;
            end else if (state == GNT1 && !m1_cyc) begin
                last_owner <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_next = last_owner ? GNT0 : GNT1;
                end else if (m0_cyc) begin
                    state_next = GNT0;
                end else if (m1_cyc) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc) begin
                    state_next = m1_cyc ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc) begin
                    state_next = m0_cyc ? GNT0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_watchdog
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

            logic [CW-1:0] wd_cnt;
            logic          wd_pending;

            // An ACK or ERR in the same cycle as the limit suppresses the abort
            assign wd_pending    = (state != IDLE) && own_stb && !s_ack && !s_err;
            assign timeout_abort = wd_pending && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

            always_ff @(posedge clk) begin
                if (rst) begin
                    wd_cnt <= '0;
                end else if (state_next != state || !wd_pending || timeout_abort) begin
                    wd_cnt <= '0;
                end else begin
                    wd_cnt <= wd_cnt + CW'(1);
                end
            end
        end else begin : g_no_watchdog
            assign timeout_abort = 1'b0;
        end
    endgenerate

    always_comb begin
        s_adr    = '0;
        s_dat_w  = '0;
        s_sel    = '0;
        s_we     = 1'b0;
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m0_dat_r = '0;
        m1_dat_r = '0;
        grant    = {state == GNT1, state == GNT0};
        case (state)
            GNT0: begin
                s_adr    = m0_adr;
                s_dat_w  = m0_dat_w;
                s_sel    = m0_sel;
                s_we     = m0_we;
                s_cyc    = m0_cyc & ~timeout_abort;
                s_stb    = m0_stb & ~timeout_abort;
                m0_ack   = s_ack;
                m0_err   = s_err | timeout_abort;
                m0_dat_r = s_dat_r;
                m1_dat_r = s_dat_r;
            end
            GNT1: begin
                s_adr    = m1_adr;
                s_dat_w  = m1_dat_w;
                s_sel    = m1_sel;
                s_we     = m1_we;
                s_cyc    = m1_cyc & ~timeout_abort;
                s_stb    = m1_stb & ~timeout_abort;
                m1_ack   = s_ack;
                m1_err   = s_err | timeout_abort;
                m0_dat_r = s_dat_r;
                m1_dat_r = s_dat_r;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_2x1.sv
// Directed self-checking bench for wb_arbiter_2x1 with an 8-cycle watchdog.
// A small registered-ACK memory plays the slave; slave_en lets it go silent.
module tb_wb_arbiter_2x1;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m0_adr, m1_adr, s_adr;
    logic [DW-1:0] m0_dat_w, m1_dat_w, s_dat_w;
    logic [DW-1:0] m0_dat_r, m1_dat_r, s_dat_r;
    logic          m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
    logic          m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
    logic [SW-1:0] m0_sel, m1_sel, s_sel;
    logic          s_cyc, s_stb, s_we, s_ack, s_err;
    logic [1:0]    grant;

    logic          slave_en;
    logic [31:0]   mem [256];
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    wb_arbiter_2x1 #(
        .WB_ADDR_WIDTH (AW),
        .WB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r), .m0_cyc(m0_cyc),
        .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r), .m1_cyc(m1_cyc),
        .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_cyc(s_cyc), .s_stb(s_stb),
        .s_we(s_we), .s_sel(s_sel), .s_ack(s_ack), .s_err(s_err),
        .grant(grant)
    );

    assign s_err = 1'b0;

    // Slave acks one cycle after a strobe and never on two consecutive cycles
    always @(posedge clk) begin
        if (rst) begin
            s_ack   <= 1'b0;
            s_dat_r <= '0;
        end else if (slave_en && s_cyc && s_stb && !s_ack) begin
            s_ack   <= 1'b1;
            s_dat_r <= mem[s_adr[9:2]];
            if (s_we) mem[s_adr[9:2]] <= s_dat_w;
        end else begin
            s_ack <= 1'b0;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic drive_m0(input logic cyc, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        m0_cyc = cyc; m0_stb = cyc; m0_we = we; m0_adr = adr; m0_dat_w = dat; m0_sel = 4'hF;
    endtask

    task automatic drive_m1(input logic cyc, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        m1_cyc = cyc; m1_stb = cyc; m1_we = we; m1_adr = adr; m1_dat_w = dat; m1_sel = 4'hF;
    endtask

    task automatic wait_ack(input int m, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((m == 0) ? m0_ack : m1_ack) !== 1'b1 && n < 20);
        check_output(tag, (m == 0) ? m0_ack : m1_ack, 1);
    endtask

    task automatic check_all_idle(input string tag);
        check_output({tag, "_grant"}, grant, 0);
        check_output({tag, "_s_cyc"}, s_cyc, 0);
        check_output({tag, "_s_stb"}, s_stb, 0);
        check_output({tag, "_s_we"}, s_we, 0);
        check_output({tag, "_s_adr"}, s_adr, 0);
        check_output({tag, "_s_dat_w"}, s_dat_w, 0);
        check_output({tag, "_s_sel"}, s_sel, 0);
        check_output({tag, "_m0_ack"}, m0_ack, 0);
        check_output({tag, "_m0_err"}, m0_err, 0);
        check_output({tag, "_m1_ack"}, m1_ack, 0);
        check_output({tag, "_m1_err"}, m1_err, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst      = 1'b1;
        slave_en = 1'b1;
        drive_m0(0, 0, 0, 0);
        drive_m1(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check_all_idle("reset");
        rst = 1'b0;

        // Single write then read by m0 with m1 idle
        drive_m0(1, 1, 32'h100, 32'hDEADBEEF);
        check_output("t1_grant_pre", grant, 0);
        @(negedge clk);
        check_output("t1_grant", grant, 2'b01);
        check_output("t1_s_adr", s_adr, 32'h100);
        check_output("t1_s_dat_w", s_dat_w, 32'hDEADBEEF);
        check_output("t1_s_we", s_we, 1);
        check_output("t1_ack_early", m0_ack, 0);
        @(negedge clk);
        check_output("t1_wr_ack", m0_ack, 1);
        check_output("t1_m1_ack", m1_ack, 0);
        drive_m0(0, 0, 0, 0);
        @(negedge clk);
        check_output("t1_release", grant, 0);
        drive_m0(1, 0, 32'h100, 0);
        @(negedge clk);
        check_output("t1_rd_grant", grant, 2'b01);
        @(negedge clk);
        check_output("t1_rd_ack", m0_ack, 1);
        check_output("t1_rd_data", m0_dat_r, 32'hDEADBEEF);
        drive_m0(0, 0, 0, 0);
        @(negedge clk);

        // Tie after reset, direct handover, round-robin on later ties
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive_m0(1, 1, 32'h104, 32'h11111111);
        drive_m1(1, 1, 32'h108, 32'h22222222);
        @(negedge clk);
        check_output("t2_tie_m0", grant, 2'b01);
        @(negedge clk);
        check_output("t2_m0_ack", m0_ack, 1);
        check_output("t2_m1_noack", m1_ack, 0);
        drive_m0(0, 0, 0, 0);
        @(negedge clk);
        check_output("t2_switch", grant, 2'b10);
        check_output("t2_s_adr", s_adr, 32'h108);
        @(negedge clk);
        check_output("t2_m1_ack", m1_ack, 1);
        check_output("t2_m0_noack", m0_ack, 0);
        drive_m1(0, 0, 0, 0);
        @(negedge clk);
        check_output("t2_idle", grant, 0);
        drive_m0(1, 0, 32'h104, 0);
        drive_m1(1, 0, 32'h108, 0);
        @(negedge clk);
        check_output("t2_tie2_m0", grant, 2'b01);
        drive_m0(0, 0, 0, 0);
        drive_m1(0, 0, 0, 0);
        @(negedge clk);
        drive_m0(1, 0, 32'h104, 0);
        drive_m1(1, 0, 32'h108, 0);
        @(negedge clk);
        check_output("t2_tie3_m1", grant, 2'b10);
        drive_m0(0, 0, 0, 0);
        drive_m1(0, 0, 0, 0);
        @(negedge clk);

        // Four-beat burst from m0 while m1 waits, then m1 reads one of the burst words
        drive_m0(1, 1, 32'h1000, 32'hA0A0A0A0);
        drive_m1(1, 0, 32'h1004, 0);
        for (int b = 0; b < 4; b++) begin
            wait_ack(0, "t3_beat_ack");
            check_output("t3_grant_hold", grant, 2'b01);
            check_output("t3_m1_noack", m1_ack, 0);
            if (b < 3) begin
                m0_adr   = 32'h1000 + 32'(4 * (b + 1));
                m0_dat_w = 32'hA0A0A0A0 + 32'(b + 1);
            end else begin
                drive_m0(0, 0, 0, 0);
            end
        end
        @(negedge clk);
        check_output("t3_switch", grant, 2'b10);
        wait_ack(1, "t3_m1_ack");
        check_output("t3_m1_data", m1_dat_r, 32'hA0A0A0A1);
        drive_m1(0, 0, 0, 0);
        @(negedge clk);

        // Silent slave: watchdog fires on the eighth cycle
        slave_en = 1'b0;
        drive_m0(1, 0, 32'h300, 0);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            check_output("t4_no_err_early", m0_err, 0);
        end
        @(negedge clk);
        check_output("t4_err", m0_err, 1);
        check_output("t4_ack", m0_ack, 0);
        check_output("t4_s_stb", s_stb, 0);
        check_output("t4_s_cyc", s_cyc, 0);
        @(negedge clk);
        check_output("t4_err_one_cycle", m0_err, 0);
        check_output("t4_s_stb_back", s_stb, 1);
        drive_m0(0, 0, 0, 0);
        @(negedge clk);
        check_output("t4_release", grant, 0);

        // ACK lands in the same cycle the watchdog would fire
        drive_m0(1, 0, 32'h1000, 0);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
        end
        slave_en = 1'b1;
        @(negedge clk);
        check_output("t5_ack", m0_ack, 1);
        check_output("t5_no_err", m0_err, 0);
        check_output("t5_s_stb", s_stb, 1);
        check_output("t5_data", m0_dat_r, 32'hA0A0A0A0);
        drive_m0(0, 0, 0, 0);
        @(negedge clk);

        // Reset in the middle of an m1 access
        slave_en = 1'b0;
        drive_m1(1, 1, 32'h2000, 32'h55);
        @(negedge clk);
        check_output("t6_grant", grant, 2'b10);
        check_output("t6_s_cyc", s_cyc, 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_idle("t6_rst");
        rst = 1'b0;
        drive_m0(1, 0, 32'h100, 0);
        @(negedge clk);
        check_output("t6_tie_m0", grant, 2'b01);
        drive_m0(0, 0, 0, 0);
        drive_m1(0, 0, 0, 0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
